// File: rtl/trace_buffer_if.sv
// Capture (retire record) and drain (valid/ready) buses of trace_buffer.
// rd_ts is present only when TRACE_TIMESTAMP_EN is defined.
interface trace_buffer_if #(
    parameter int PC_W    = 16,
    parameter int INSTR_W = 16,
    parameter int DATA_W  = 16,
    parameter int REG_AW  = 4
);
    logic               cap_valid;
    logic [PC_W-1:0]    cap_pc;
    logic [INSTR_W-1:0] cap_instr;
    logic               cap_wb_en;
    logic [REG_AW-1:0]  cap_wb_addr;
    logic [DATA_W-1:0]  cap_wb_data;

    logic               rd_ready;
    logic               rd_valid;
    logic [PC_W-1:0]    rd_pc;
    logic [INSTR_W-1:0] rd_instr;
    logic               rd_wb_en;
    logic [REG_AW-1:0]  rd_wb_addr;
    logic [DATA_W-1:0]  rd_wb_data;
`ifdef TRACE_TIMESTAMP_EN
    logic [15:0]        rd_ts;
`endif

    modport master (
        output cap_valid, cap_pc, cap_instr, cap_wb_en, cap_wb_addr, cap_wb_data, rd_ready,
`ifdef TRACE_TIMESTAMP_EN
        input  rd_ts,
`endif
        input  rd_valid, rd_pc, rd_instr, rd_wb_en, rd_wb_addr, rd_wb_data
    );

    modport slave (
        input  cap_valid, cap_pc, cap_instr, cap_wb_en, cap_wb_addr, cap_wb_data, rd_ready,
`ifdef TRACE_TIMESTAMP_EN
        output rd_ts,
`endif
        output rd_valid, rd_pc, rd_instr, rd_wb_en, rd_wb_addr, rd_wb_data
    );
endinterface

// File: rtl/trace_buffer.sv
// Circular execution-trace buffer: capture until POST_TRIG entries after a trigger, then drain oldest-first.
// Optional per-entry cycle timestamp when TRACE_TIMESTAMP_EN is defined.
module trace_buffer #(
    parameter int PC_W      = 16,
    parameter int INSTR_W   = 16,
    parameter int DATA_W    = 16,
    parameter int REG_AW    = 4,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    trace_buffer_if.slave           bus,
    input  logic                    arm,
    input  logic                    trig_en,
    input  logic [PC_W-1:0]         trig_pc,
    input  logic                    force_trig,
    output logic [1:0]              state,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    wrapped
);
    localparam int AW   = $clog2(DEPTH);
    localparam int TS_W = 16;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_POST  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW-1:0] POST_LD  = AW'(POST_TRIG);

    typedef struct packed {
`ifdef TRACE_TIMESTAMP_EN
        logic [TS_W-1:0]    ts;
`endif
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic               wb_en;
        logic [REG_AW-1:0]  wb_addr;
        logic [DATA_W-1:0]  wb_data;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        wr_ent, rd_ent;
    logic [AW-1:0] wr_ptr, rd_ptr, post_cnt;
    logic          capturing, cap_we, trig_hit, full, rd_valid, pop;

`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt;

    always_ff @(posedge clk) begin
        if (!rst) ts_cnt <= '0;
        else      ts_cnt <= ts_cnt + TS_W'(1);
    end
`endif

    always_comb begin
        capturing = (state == S_ARMED) || (state == S_POST);
        // arm wins over a same-cycle retire, so the record is dropped
        cap_we    = rst & ~arm & bus.cap_valid & capturing;
        trig_hit  = (state == S_ARMED) & bus.cap_valid &
                    ((trig_en & (bus.cap_pc == trig_pc)) | force_trig);
        full      = (count == CNT_FULL);
        rd_valid  = (state == S_DONE) && (count != '0);
        pop       = rd_valid & bus.rd_ready;
    end

    always_comb begin
        wr_ent         = '0;
`ifdef TRACE_TIMESTAMP_EN
        wr_ent.ts      = ts_cnt;
`endif
        wr_ent.pc      = bus.cap_pc;
        wr_ent.instr   = bus.cap_instr;
        wr_ent.wb_en   = bus.cap_wb_en;
        wr_ent.wb_addr = bus.cap_wb_addr;
        wr_ent.wb_data = bus.cap_wb_data;
    end

    always_ff @(posedge clk) begin
        if (cap_we) mem[wr_ptr] <= wr_ent;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            wrapped  <= 1'b0;
            post_cnt <= '0;
        end else if (arm) begin
            state    <= S_ARMED;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            wrapped  <= 1'b0;
            post_cnt <= '0;
        end else begin
            if (cap_we) begin
                wr_ptr <= wr_ptr + PTR_ONE;
                // when full the oldest entry is overwritten, so the read side slides along
                if (full) begin
                    rd_ptr  <= rd_ptr + PTR_ONE;
                    wrapped <= 1'b1;
                end else begin
                    count <= count + CNT_ONE;
                end
                if (trig_hit) begin
                    post_cnt <= POST_LD;
                    state    <= (POST_TRIG == 0) ? S_DONE : S_POST;
                end else if (state == S_POST) begin
                    post_cnt <= post_cnt - PTR_ONE;
                    if (post_cnt == PTR_ONE) state <= S_DONE;
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
                count  <= count - CNT_ONE;
                if (count == CNT_ONE) state <= S_IDLE;
            end
        end
    end

    assign rd_ent         = mem[rd_ptr];
    assign bus.rd_valid   = rd_valid;
    assign bus.rd_pc      = rd_valid ? rd_ent.pc      : '0;
    assign bus.rd_instr   = rd_valid ? rd_ent.instr   : '0;
    assign bus.rd_wb_en   = rd_valid ? rd_ent.wb_en   : 1'b0;
    assign bus.rd_wb_addr = rd_valid ? rd_ent.wb_addr : '0;
    assign bus.rd_wb_data = rd_valid ? rd_ent.wb_data : '0;
`ifdef TRACE_TIMESTAMP_EN
    assign bus.rd_ts      = rd_valid ? rd_ent.ts      : '0;
`endif
endmodule

// File: tb/tb_trace_buffer.sv
// Randomized + directed bench for trace_buffer: dut0 (DEPTH 8, POST_TRIG 2) vs a queue model,
// dut1 (POST_TRIG 0) for the immediate force-trigger case. Honors TRACE_TIMESTAMP_EN.
module tb_trace_buffer;
    localparam int DEPTH = 8;
    localparam int POST  = 2;

    logic        clk = 1'b0;
    logic        rst, arm, trig_en, force_trig, rd_ready;
    logic        cap_valid, cap_wb_en;
    logic [15:0] cap_pc, cap_instr, cap_wb_data, trig_pc;
    logic [3:0]  cap_wb_addr;
    logic [1:0]  state0, state1;
    logic [3:0]  count0, count1;
    logic        wrapped0, wrapped1;

    always #5 clk = ~clk;

    trace_buffer_if if0 ();
    trace_buffer_if if1 ();

    assign if0.cap_valid = cap_valid;     assign if1.cap_valid = cap_valid;
    assign if0.cap_pc = cap_pc;           assign if1.cap_pc = cap_pc;
    assign if0.cap_instr = cap_instr;     assign if1.cap_instr = cap_instr;
    assign if0.cap_wb_en = cap_wb_en;     assign if1.cap_wb_en = cap_wb_en;
    assign if0.cap_wb_addr = cap_wb_addr; assign if1.cap_wb_addr = cap_wb_addr;
    assign if0.cap_wb_data = cap_wb_data; assign if1.cap_wb_data = cap_wb_data;
    assign if0.rd_ready = rd_ready;       assign if1.rd_ready = rd_ready;

    trace_buffer #(.DEPTH(DEPTH), .POST_TRIG(POST)) dut0 (
        .clk(clk), .rst(rst), .bus(if0.slave), .arm(arm), .trig_en(trig_en),
        .trig_pc(trig_pc), .force_trig(force_trig), .state(state0), .count(count0),
        .wrapped(wrapped0));

    trace_buffer #(.DEPTH(DEPTH), .POST_TRIG(0)) dut1 (
        .clk(clk), .rst(rst), .bus(if1.slave), .arm(arm), .trig_en(trig_en),
        .trig_pc(trig_pc), .force_trig(force_trig), .state(state1), .count(count1),
        .wrapped(wrapped1));

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] instr;
        logic        we;
        logic [3:0]  wa;
        logic [15:0] wd;
        logic [15:0] ts;
    } rec_t;

    // reference model: the buffer is just a bounded queue of records
    rec_t        q[$];
    int          m_state = 0;
    bit          m_wrap  = 0;
    int          m_post  = 0;
    logic [15:0] m_ts    = '0;
    int          n_chk   = 0;
    int          n_err   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        rec_t r;
        if (!rst) begin
            q.delete(); m_state = 0; m_wrap = 0; m_post = 0; m_ts = '0;
            return;
        end
        if (arm) begin
            q.delete(); m_wrap = 0; m_post = 0; m_state = 1;
        end else if ((m_state == 1 || m_state == 2) && cap_valid) begin
            r.pc = cap_pc; r.instr = cap_instr; r.we = cap_wb_en;
            r.wa = cap_wb_addr; r.wd = cap_wb_data; r.ts = m_ts;
            q.push_back(r);
            if (q.size() > DEPTH) begin
                void'(q.pop_front());
                m_wrap = 1;
            end
            if (m_state == 1) begin
                if ((trig_en && cap_pc == trig_pc) || force_trig) begin
                    m_post  = POST;
                    m_state = (POST == 0) ? 3 : 2;
                end
            end else begin
                m_post--;
                if (m_post == 0) m_state = 3;
            end
        end else if (m_state == 3 && q.size() != 0 && rd_ready) begin
            void'(q.pop_front());
            if (q.size() == 0) m_state = 0;
        end
        m_ts++;
    endtask

    task automatic check_model();
        rec_t e;
        bit   v;
        v = (m_state == 3) && (q.size() != 0);
        e = v ? q[0] : '0;
        chk("state",    32'(state0),         32'(m_state));
        chk("count",    32'(count0),         32'(q.size()));
        chk("wrapped",  32'(wrapped0),       32'(m_wrap));
        chk("rd_valid", 32'(if0.rd_valid),   32'(v));
        chk("rd_pc",    32'(if0.rd_pc),      32'(e.pc));
        chk("rd_instr", 32'(if0.rd_instr),   32'(e.instr));
        chk("rd_wb_en", 32'(if0.rd_wb_en),   32'(e.we));
        chk("rd_wb_ad", 32'(if0.rd_wb_addr), 32'(e.wa));
        chk("rd_wb_d",  32'(if0.rd_wb_data), 32'(e.wd));
`ifdef TRACE_TIMESTAMP_EN
        chk("rd_ts",    32'(if0.rd_ts),      32'(e.ts));
`endif
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic retire(input logic [15:0] pc);
        cap_valid   = 1'b1;
        cap_pc      = pc;
        cap_instr   = 16'($urandom);
        cap_wb_en   = 1'($urandom);
        cap_wb_addr = 4'($urandom);
        cap_wb_data = 16'($urandom);
        tick();
        cap_valid   = 1'b0;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    logic [15:0] held;

    initial begin
        rst = 1'b0; arm = 1'b0; trig_en = 1'b0; trig_pc = '0; force_trig = 1'b0;
        rd_ready = 1'b0; cap_valid = 1'b1; cap_pc = 16'h1234; cap_instr = '0;
        cap_wb_en = 1'b0; cap_wb_addr = '0; cap_wb_data = '0;

        // reset with a retire pending
        tick(); tick();
        chk("rst_state", 32'(state0), 0);
        chk("rst_count", 32'(count0), 0);
        chk("rst_valid", 32'(if0.rd_valid), 0);
        chk("rst_pc",    32'(if0.rd_pc), 0);
        rst = 1'b1; cap_valid = 1'b0;
        tick();

        // basic trigger at PC 2
        do_arm();
        trig_en = 1'b1; trig_pc = 16'd2;
        for (int i = 0; i < 5; i++) retire(16'(i));
        chk("basic_state", 32'(state0), 3);
        chk("basic_count", 32'(count0), 5);
        rd_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("basic_drain", 32'(if0.rd_pc), 32'(i));
            tick();
        end
        chk("basic_idle", 32'(state0), 0);
        rd_ready = 1'b0;

        // wrap: 12 retires, trigger at PC 9
        do_arm();
        trig_pc = 16'd9;
        for (int i = 0; i < 12; i++) retire(16'(i));
        chk("wrap_state",   32'(state0), 3);
        chk("wrap_count",   32'(count0), 8);
        chk("wrap_wrapped", 32'(wrapped0), 1);
        chk("wrap_oldest",  32'(if0.rd_pc), 4);

        // backpressure 1,0,0,1
        rd_ready = 1'b1; tick();
        held = if0.rd_pc;
        chk("bp_pop1", 32'(held), 5);
        rd_ready = 1'b0; tick();
        chk("bp_stall1", 32'(if0.rd_pc), 32'(held));
        tick();
        chk("bp_stall2", 32'(if0.rd_pc), 32'(held));
        chk("bp_stallv", 32'(if0.rd_valid), 1);
        rd_ready = 1'b1; tick();
        chk("bp_pops", 32'(count0), 6);
        for (int i = 6; i < 12; i++) begin
            chk("wrap_drain", 32'(if0.rd_pc), 32'(i));
            tick();
        end
        chk("wrap_idle", 32'(state0), 0);
        rd_ready = 1'b0;

        // force trigger; POST_TRIG=0 instance finishes immediately
        do_arm();
        trig_en = 1'b0; force_trig = 1'b1;
        tick();
        chk("force_nocap", 32'(state1), 1);
        retire(16'd7);
        force_trig = 1'b0;
        chk("force_state1", 32'(state1), 3);
        chk("force_count1", 32'(count1), 1);
        chk("force_pc1",    32'(if1.rd_pc), 7);
        chk("force_valid1", 32'(if1.rd_valid), 1);
        chk("force_state0", 32'(state0), 2);

        // arm during POST with a retire in the same cycle
        do_arm();
        for (int i = 0; i < 10; i++) retire(16'(16'h20 + i));
        chk("ap_wrapped", 32'(wrapped0), 1);
        force_trig = 1'b1; retire(16'h30); force_trig = 1'b0;
        chk("ap_post", 32'(state0), 2);
        arm = 1'b1; cap_valid = 1'b1; cap_pc = 16'h55;
        tick();
        arm = 1'b0; cap_valid = 1'b0;
        chk("ap_state",   32'(state0), 1);
        chk("ap_count",   32'(count0), 0);
        chk("ap_wrapped0", 32'(wrapped0), 0);
        force_trig = 1'b1; retire(16'h66); force_trig = 1'b0;
        retire(16'h67); retire(16'h68);
        chk("ap_done",  32'(state0), 3);
        chk("ap_first", 32'(if0.rd_pc), 16'h66);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            rst         = ($urandom_range(0, 299) != 0);
            arm         = ($urandom_range(0, 39) == 0);
            cap_valid   = ($urandom_range(0, 2) != 0);
            cap_pc      = 16'($urandom_range(0, 15));
            cap_instr   = 16'($urandom);
            cap_wb_en   = 1'($urandom);
            cap_wb_addr = 4'($urandom);
            cap_wb_data = 16'($urandom);
            trig_en     = 1'($urandom);
            trig_pc     = 16'($urandom_range(0, 15));
            force_trig  = ($urandom_range(0, 19) == 0);
            rd_ready    = 1'($urandom);
            tick();
        end
        rst = 1'b1; arm = 1'b0; cap_valid = 1'b0; force_trig = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
